ex_operand_fetch: RTL
=====================

Name: ex_operand_fetch

Overview:
- EX-side reader of the 93-bit ID/EX bundle.
- Unpacks the bundle fields and resolves operand A/B through forwarding from two internal writeback-tracking stages (EX/MEM, MEM/WB).
- Detects load-use hazards and drives stall/bubble back toward the ID/EX register.
- Presents resolved operands and control to the ALU; sits between the ID/EX register output and the ALU / EX/MEM register input.

Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- BW, 93, ID/EX bundle width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- idex_in  input  93  ID/EX bundle
- alu_result  input  32  ALU result for the instruction currently issued
- mem_rdata  input  32  load data returning for the instruction in the MEM slot
- op_a  output  32  forwarded operand A
- op_b  output  32  forwarded operand B
- alu_ctrl  output  4  bundle[68:65]
- cin  output  1  bundle[74]
- issue  output  1  instruction issued to ALU this cycle
- stall  output  1  hold PC/IF_ID/ID_EX
- bubble  output  1  zero ID_EX input next edge
- wb_we  output  1  MEM/WB write enable to register file
- wb_addr  output  5  MEM/WB destination
- wb_data  output  32  MEM/WB write data

Behaviour:
- Bundle map:
  - [31:0] A, [63:32] B, [64] WE, [68:65] ALU ctrl, [73:69] dest, [74] Cin
  - [79:75] srcA addr, [84:80] srcB addr, [85] is_load, [86] valid
  - [92:87] ignored
- Internal stages, each holding {valid, we, is_load, dest, data}:
  - EXM (EX/MEM slot), captured on issue: data=alu_result.
  - MWB (MEM/WB slot), captured from EXM every cycle: data = mem_rdata if EXM.is_load, else EXM.data.
- Forwarding priority for operand A (B identical with srcB and B field):
  - EXM hit: EXM.valid & EXM.we & !EXM.is_load & EXM.dest!=0 & EXM.dest==srcA → EXM.data.
  - Else MWB hit (same conditions, is_load allowed) → MWB.data.
  - Else bundle field A.
  - Address 0 never forwards.
- Hazard FSM, states RUN and LSTALL:
  - RUN: if valid & EXM.valid & EXM.is_load & EXM.we & EXM.dest!=0 & (dest matches srcA or srcB) → stall=1, issue=0, EXM loads a bubble (valid=0), next LSTALL.
  - RUN otherwise: issue=valid, stall=0.
  - LSTALL: the load has now moved to MWB and forwarding covers it. issue=valid, stall=0, next RUN.
  - A second dependent load back-to-back re-enters LSTALL from RUN normally.
- bubble equals stall combinationally; stall, bubble, op_a, op_b and issue are combinational from current state and inputs.
- wb_we = MWB.valid & MWB.we & MWB.dest!=0; wb_addr/wb_data from MWB.
- Invalid bundle (valid=0) issues nothing, and EXM captures valid=0.
- Reset (async, rst=0):
  - FSM returns to RUN and all stage valid/we/is_load bits clear.
  - Data and dest fields reset to 0.
  - Outputs during reset: stall=0, bubble=0, issue=0, wb_we=0, wb_addr=0, wb_data=0.
  - op_a/op_b pass bundle fields.
  - Reset mid-stall abandons the stall; the first cycle after release is RUN.
- Simultaneous EXM and MWB hits on the same register: EXM wins (newest).
- Latency: issue-to-writeback is 2 clock edges.

Test Plan:
- Reset: hold rst=0 with random idex_in → stall=0, wb_we=0, issue=0; release, valid=1 → issue=1 same cycle.
- EX forwarding:
  - Issue ADD dest=3 with alu_result=0x11.
  - Next cycle issue srcA=3 with bundle A=0xDEAD.
  - Required: op_a=0x11.
- MEM forwarding and priority:
  - Issue writes to r4 (0x22) then r5, followed by a reader of srcB=4 → op_b=0x22.
  - Same sequence with both older writes to r4 → newer value wins.
- Load-use:
  - Load dest=7 issued, mem_rdata=0xCAFE next cycle; dependent srcA=7 arrives.
  - Required: one cycle stall=1/bubble=1/issue=0.
  - Following cycle op_a=0xCAFE, issue=1.
  - r7 written with 0xCAFE.
- r0 guard: write dest=0 with alu_result=0x99, then read srcA=0 → op_a = bundle A; wb_we=0.
- Reset during LSTALL: assert rst=0 in the stall cycle → stall drops immediately; after release no forwarding from the pre-reset load.

Source files
------------

// File: rtl/ex_operand_fetch_if.sv
// ex_operand_fetch_if: ID/EX bundle, ALU/memory return data and EX-side
// results (operands, control, hazard and writeback signals) in one bundle.
interface ex_operand_fetch_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int BW = 93
);
    logic [BW-1:0] idex_in;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [3:0]    alu_ctrl;
    logic          cin;
    logic          issue;
    logic          stall;
    logic          bubble;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    modport master (
        output idex_in, alu_result, mem_rdata,
        input  op_a, op_b, alu_ctrl, cin, issue, stall, bubble,
               wb_we, wb_addr, wb_data
    );

    modport slave (
        input  idex_in, alu_result, mem_rdata,
        output op_a, op_b, alu_ctrl, cin, issue, stall, bubble,
               wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/ex_operand_fetch.sv
// ex_operand_fetch: unpacks the ID/EX bundle, forwards operands from the
// internal EX/MEM and MEM/WB tracking stages, and raises a one-cycle stall
// when an instruction depends on a load still in the EX/MEM slot.
module ex_operand_fetch #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int BW = 93
) (
    input logic              clk,
    input logic              rst,
    ex_operand_fetch_if.slave bus
);
    // Bundle field positions
    localparam int P_WE   = 2 * DW;
    localparam int P_CTL  = 2 * DW + 1;
    localparam int P_DST  = 2 * DW + 5;
    localparam int P_CIN  = P_DST + AW;
    localparam int P_SRCA = P_CIN + 1;
    localparam int P_SRCB = P_SRCA + AW;
    localparam int P_LD   = P_SRCB + AW;
    localparam int P_VAL  = P_LD + 1;

    typedef enum logic {RUN, LSTALL} state_t;

    state_t        state;

    logic          exm_valid, exm_we, exm_is_load;
    logic [AW-1:0] exm_dest;
    logic [DW-1:0] exm_data;

    logic          mwb_valid, mwb_we, mwb_is_load;
    logic [AW-1:0] mwb_dest;
    logic [DW-1:0] mwb_data;

    logic [DW-1:0] fld_a, fld_b;
    logic [AW-1:0] src_a, src_b, dest;
    logic          valid, is_load, we;
    logic          exm_fwd_ok, mwb_fwd_ok, load_hazard, issue_int;
    logic          unused_hi;

    // Unpack the bundle
    always_comb begin
        fld_a     = bus.idex_in[DW-1:0];
        fld_b     = bus.idex_in[2*DW-1:DW];
        we        = bus.idex_in[P_WE];
        dest      = bus.idex_in[P_DST +: AW];
        src_a     = bus.idex_in[P_SRCA +: AW];
        src_b     = bus.idex_in[P_SRCB +: AW];
        is_load   = bus.idex_in[P_LD];
        valid     = bus.idex_in[P_VAL];
        unused_hi = ^bus.idex_in[BW-1:P_VAL+1] ^ mwb_is_load;
    end

    // Hazard detection and issue decision for the current cycle
    always_comb begin
        exm_fwd_ok  = exm_valid & exm_we & ~exm_is_load & (exm_dest != '0);
        mwb_fwd_ok  = mwb_valid & mwb_we & (mwb_dest != '0);
        load_hazard = rst & (state == RUN) & valid & exm_valid & exm_is_load &
                      exm_we & (exm_dest != '0) &
                      ((exm_dest == src_a) | (exm_dest == src_b));
        issue_int   = rst & valid & ~load_hazard;
    end

    // Operand resolution: EX/MEM (newest) beats MEM/WB beats the bundle
    always_comb begin
        bus.op_a = fld_a;
        bus.op_b = fld_b;
        if (exm_fwd_ok && exm_dest == src_a)      bus.op_a = exm_data;
        else if (mwb_fwd_ok && mwb_dest == src_a) bus.op_a = mwb_data;
        if (exm_fwd_ok && exm_dest == src_b)      bus.op_b = exm_data;
        else if (mwb_fwd_ok && mwb_dest == src_b) bus.op_b = mwb_data;
    end

    // Control, hazard and writeback outputs
    always_comb begin
        bus.alu_ctrl = bus.idex_in[P_CTL +: 4];
        bus.cin      = bus.idex_in[P_CIN];
        bus.issue    = issue_int;
        bus.stall    = load_hazard;
        bus.bubble   = load_hazard;
        bus.wb_we    = mwb_valid & mwb_we & (mwb_dest != '0);
        bus.wb_addr  = mwb_dest;
        bus.wb_data  = mwb_data;
    end

    // Hazard FSM: a stall always lasts exactly one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= load_hazard ? LSTALL : RUN;
                LSTALL:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // EX/MEM tracking stage: captures issued instructions, bubble otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_valid   <= 1'b0;
            exm_we      <= 1'b0;
            exm_is_load <= 1'b0;
            exm_dest    <= '0;
            exm_data    <= '0;
        end else if (issue_int) begin
            exm_valid   <= 1'b1;
            exm_we      <= we;
            exm_is_load <= is_load;
            exm_dest    <= dest;
            exm_data    <= bus.alu_result;
        end else begin
            exm_valid   <= 1'b0;
            exm_we      <= 1'b0;
            exm_is_load <= 1'b0;
        end
    end

    // MEM/WB tracking stage: loads pick up the returning memory data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mwb_valid   <= 1'b0;
            mwb_we      <= 1'b0;
            mwb_is_load <= 1'b0;
            mwb_dest    <= '0;
            mwb_data    <= '0;
        end else begin
            mwb_valid   <= exm_valid;
            mwb_we      <= exm_we;
            mwb_is_load <= exm_is_load;
            mwb_dest    <= exm_dest;
            mwb_data    <= exm_is_load ? bus.mem_rdata : exm_data;
        end
    end
endmodule
